// File: rtl/ucode_seq.sv
// ucode_seq -- parametrised microcode sequencer.
//
// The micro-ROM has NUM_OPS slots of SLOT_DEPTH entries, one slot per macro-op.
// A decode trigger (start) latches the macro operands and replays the slot.
// Each emitted micro-instruction can have its dest, source and immediate
// fields replaced by the latched operands. While a slot is replaying, the
// block drives the fetch/ucode mux select and holds fetch.
//
// Build option:
//   UCODE_ABORT_EN - adds the abort input. When abort=1 in RUN, the sequence
//                    is dropped at the next clock edge, whatever advance is.
//                    No done pulse is produced and the repeat counter clears.
//
// Ports:
//   clk        core clock
//   rst        asynchronous reset, active low
//   advance    clock enable for all sequencer state, including ROM writes
//   start      macro-op trigger from decode (used only in IDLE)
//   op_sel     slot select
//   dest_reg   macro dest register
//   src_reg    macro first-source register
//   imm        macro immediate; its low LOOP_W bits load the repeat counter
//   rom_we     ROM write strobe (accepted only in IDLE)
//   rom_addr   ROM write address
//   rom_wdata  {END, LOOP, SUB_D, SUB_S, template[INST_W-1:0]}
//              SUB_I is template bit IMM_LSB+IMM_W
//   abort      (UCODE_ABORT_EN only) branch override from EXE
//   mux_ctrl   1 = decode takes uinst
//   uinst      micro-instruction after field substitution
//   busy       sequence in progress; fetch holds PC
//   done       one-cycle pulse after the last micro-instruction
//   upc        current micro-PC
//
// States:
//   state  | meaning
//   IDLE   | waiting for start; ROM writable; outputs quiet
//   RUN    | replaying slot at upc; mux_ctrl and busy high
module ucode_seq #(
  parameter int INST_W     = 32,
  parameter int REG_W      = 4,
  parameter int IMM_W      = 16,
  parameter int NUM_OPS    = 4,
  parameter int SLOT_DEPTH = 16,
  parameter int LOOP_W     = 5,
  parameter int DEST_LSB   = 23,
  parameter int SRC_LSB    = 19,
  parameter int IMM_LSB    = 0,
  localparam int OP_W      = $clog2(NUM_OPS),
  localparam int ADDR_W    = $clog2(NUM_OPS * SLOT_DEPTH),
  localparam int ENTRY_W   = INST_W + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic               start,
  input  logic [OP_W-1:0]    op_sel,
  input  logic [REG_W-1:0]   dest_reg,
  input  logic [REG_W-1:0]   src_reg,
  input  logic [IMM_W-1:0]   imm,
  input  logic               rom_we,
  input  logic [ADDR_W-1:0]  rom_addr,
  input  logic [ENTRY_W-1:0] rom_wdata,
`ifdef UCODE_ABORT_EN
  input  logic               abort,
`endif
  output logic               mux_ctrl,
  output logic [INST_W-1:0]  uinst,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  upc
);

  localparam int SLOT_BITS = $clog2(SLOT_DEPTH);
  localparam int ROM_DEPTH = NUM_OPS * SLOT_DEPTH;
  localparam int BIT_END   = INST_W + 3;
  localparam int BIT_LOOP  = INST_W + 2;
  localparam int BIT_SUB_D = INST_W + 1;
  localparam int BIT_SUB_S = INST_W;
  localparam int BIT_SUB_I = IMM_LSB + IMM_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  upc_q, upc_d;
  logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d;
  logic [REG_W-1:0]   dest_q, dest_d;
  logic [REG_W-1:0]   src_q, src_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic               done_q, done_d;

  // Not reset: contents survive a sequencer reset, and software reloads as needed.
  logic [ENTRY_W-1:0] rom_mem [ROM_DEPTH];
  logic [ENTRY_W-1:0] entry;
  logic               slot_last;
  logic               abort_req;
  logic               rom_wr_ok;
  logic [INST_W-1:0]  uinst_c;

  assign entry     = rom_mem[upc_q];
  assign slot_last = (upc_q[SLOT_BITS-1:0] == SLOT_BITS'(SLOT_DEPTH - 1));
  assign rom_wr_ok = advance & rom_we & (state_q == S_IDLE);

`ifdef UCODE_ABORT_EN
  assign abort_req = abort & (state_q == S_RUN);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rom_wr_ok) begin
      rom_mem[rom_addr] <= rom_wdata;
    end
  end

  // Field substitution. SUB_I shares a bit with the template, so that bit is
  // cleared before the immediate is inserted.
  always_comb begin
    uinst_c = '0;
    if (state_q == S_RUN) begin
      uinst_c = entry[INST_W-1:0];
      if (entry[BIT_SUB_D]) uinst_c[DEST_LSB +: REG_W] = dest_q;
      if (entry[BIT_SUB_S]) uinst_c[SRC_LSB +: REG_W]  = src_q;
      if (entry[BIT_SUB_I]) begin
        uinst_c[BIT_SUB_I]         = 1'b0;
        uinst_c[IMM_LSB +: IMM_W]  = imm_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    upc_d      = upc_q;
    loop_cnt_d = loop_cnt_q;
    dest_d     = dest_q;
    src_d      = src_q;
    imm_d      = imm_q;
    done_d     = done_q;

    if (advance) begin
      done_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            dest_d     = dest_reg;
            src_d      = src_reg;
            imm_d      = imm;
            upc_d      = {op_sel, {SLOT_BITS{1'b0}}};
            loop_cnt_d = imm[LOOP_W-1:0];
            state_d    = S_RUN;
          end
        end
        S_RUN: begin
          // Repeat takes priority over END, so a looping END entry repeats first.
          if (entry[BIT_LOOP] && (loop_cnt_q != '0)) begin
            loop_cnt_d = loop_cnt_q - LOOP_W'(1);
          end else if (entry[BIT_END] || slot_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            upc_d = upc_q + ADDR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (abort_req) begin
      state_d    = S_IDLE;
      upc_d      = upc_q;
      loop_cnt_d = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      upc_q      <= '0;
      loop_cnt_q <= '0;
      dest_q     <= '0;
      src_q      <= '0;
      imm_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      upc_q      <= upc_d;
      loop_cnt_q <= loop_cnt_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      imm_q      <= imm_d;
      done_q     <= done_d;
    end
  end

  assign mux_ctrl = (state_q == S_RUN);
  assign busy     = (state_q == S_RUN);
  assign uinst    = uinst_c;
  assign done     = done_q;
  assign upc      = upc_q;

endmodule

// File: tb/tb_ucode_seq.sv
module tb_ucode_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        advance = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_sel = '0;
  logic [3:0]  dest_reg = '0;
  logic [3:0]  src_reg = '0;
  logic [15:0] imm = '0;
  logic        rom_we = 1'b0;
  logic [5:0]  rom_addr = '0;
  logic [35:0] rom_wdata = '0;
`ifdef UCODE_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        mux_ctrl;
  logic [31:0] uinst;
  logic        busy;
  logic        done;
  logic [5:0]  upc;

  ucode_seq dut (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .start     (start),
    .op_sel    (op_sel),
    .dest_reg  (dest_reg),
    .src_reg   (src_reg),
    .imm       (imm),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
`ifdef UCODE_ABORT_EN
    .abort     (abort),
`endif
    .mux_ctrl  (mux_ctrl),
    .uinst     (uinst),
    .busy      (busy),
    .done      (done),
    .upc       (upc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  upc;
    logic [31:0] uinst;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [35:0] rom_m [64];
  int          checks = 0;
  int          errors = 0;
  bit          pending_done = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] subst(input logic [35:0] e, input logic [3:0] d,
                                        input logic [3:0] s, input logic [15:0] i);
    logic [31:0] t;
    t = e[31:0];
    if (e[33]) t[26:23] = d;
    if (e[32]) t[22:19] = s;
    if (e[16]) begin
      t[16]   = 1'b0;
      t[15:0] = i;
    end
    return t;
  endfunction

  // Reference: walk the slot by the sequencing rules, one queue item per RUN cycle.
  task automatic push_trace(input logic [1:0] op, input logic [3:0] d,
                            input logic [3:0] s, input logic [15:0] i);
    int a;
    int cnt;
    a   = int'(op) * 16;
    cnt = int'(i[4:0]);
    for (int n = 0; n < 100; n++) begin
      exp_t x;
      bit   fin;
      fin     = 1'b0;
      x.upc   = 6'(a);
      x.uinst = subst(rom_m[a], d, s, i);
      if (rom_m[a][34] && cnt > 0) cnt--;
      else if (rom_m[a][35] || (a % 16) == 15) fin = 1'b1;
      else a++;
      x.last = fin;
      exp_q.push_back(x);
      if (fin) break;
    end
  endtask

  always @(negedge clk) begin : monitor
    bit   have;
    bit   popped_last;
    exp_t x;
    if (mon_en) begin
      have        = (exp_q.size() != 0);
      popped_last = 1'b0;
      check("mux_ctrl", 64'(mux_ctrl), 64'(have));
      check("busy", 64'(busy), 64'(have));
      check("done", 64'(done), 64'(pending_done));
      if (have) begin
        x = exp_q[0];
        check("upc", 64'(upc), 64'(x.upc));
        check("uinst", 64'(uinst), 64'(x.uinst));
        if (advance) begin
          void'(exp_q.pop_front());
          popped_last = x.last;
        end
      end else begin
        check("uinst_idle", 64'(uinst), 64'(0));
      end
      if (advance) pending_done = popped_last;
    end
  end

  task automatic rom_write(input logic [5:0] a, input logic [35:0] d);
    rom_we    = 1'b1;
    rom_addr  = a;
    rom_wdata = d;
    advance   = 1'b1;
    @(posedge clk);
    rom_m[a] = d;
    #1;
    rom_we = 1'b0;
  endtask

  function automatic logic [35:0] rand_entry(input int end_pct);
    logic [35:0] e;
    e     = {4'($urandom), $urandom};
    e[35] = ($urandom_range(0, 99) < end_pct);
    e[34] = ($urandom_range(0, 4) == 0);
    return e;
  endfunction

  // Caller guarantees the sequencer is idle (possibly in its done cycle).
  task automatic run_seq(input logic [1:0] op, input logic [3:0] d, input logic [3:0] s,
                         input logic [15:0] i, input int stall_pct, input bit noise);
    bit ended;
    if ($urandom_range(0, 3) == 0) begin
      start   = 1'b1;
      advance = 1'b0;
      op_sel  = 2'($urandom);
      @(posedge clk);
      #1;
    end
    start    = 1'b1;
    advance  = 1'b1;
    op_sel   = op;
    dest_reg = d;
    src_reg  = s;
    imm      = i;
    @(posedge clk);
    push_trace(op, d, s, i);
    #1;
    start = 1'b0;
    ended = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (exp_q.size() == 0) begin
        ended = 1'b1;
        break;
      end
      advance = ($urandom_range(0, 99) >= stall_pct);
      if (noise) begin
        start     = 1'($urandom);
        op_sel    = 2'($urandom);
        dest_reg  = 4'($urandom);
        src_reg   = 4'($urandom);
        imm       = 16'($urandom);
        rom_we    = 1'($urandom);
        rom_addr  = 6'($urandom);
        rom_wdata = {4'($urandom), $urandom};
      end
      @(posedge clk);
      #1;
    end
    if (!ended) begin
      errors++;
      $display("FAIL seq_timeout actual=%0d expected=0 items left", exp_q.size());
      exp_q.delete();
    end
    start   = 1'b0;
    rom_we  = 1'b0;
    advance = 1'b1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      advance = 1'($urandom);
      @(posedge clk);
      #1;
    end
    advance = 1'b1;
  endtask

  task automatic reset_mid_run();
    start   = 1'b1;
    advance = 1'b1;
    op_sel  = 2'd3;
    imm     = 16'h0004;
    @(posedge clk);
    push_trace(2'd3, dest_reg, src_reg, 16'h0004);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("rst_mux_ctrl", 64'(mux_ctrl), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_uinst", 64'(uinst), 64'(0));
    check("rst_upc", 64'(upc), 64'(0));
    exp_q.delete();
    pending_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1;
    check("init_mux_ctrl", 64'(mux_ctrl), 64'(0));
    check("init_busy", 64'(busy), 64'(0));
    check("init_done", 64'(done), 64'(0));
    check("init_uinst", 64'(uinst), 64'(0));
    check("init_upc", 64'(upc), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int a = 0; a < 64; a++) rom_write(6'(a), rand_entry(25));

    // Basic slot 1: three entries, SUB_D on the first, END on the last.
    rom_write(6'd16, {4'b0010, 32'h0000_1234});
    rom_write(6'd17, {4'b0000, 32'h00AA_0000});
    rom_write(6'd18, {4'b1000, 32'h0012_3456});
    run_seq(2'd1, 4'h7, 4'h3, 16'h0000, 0, 1'b0);
    idle(2);

    // Repeat: entry 0 loops three extra times, entry 1 ends.
    rom_write(6'd0, {4'b0100, 32'h0101_0101});
    rom_write(6'd1, {4'b1000, 32'h0202_0202});
    run_seq(2'd0, 4'h1, 4'h2, 16'h0003, 0, 1'b0);

    // Stalls with advance low.
    run_seq(2'd1, 4'h9, 4'h5, 16'h0002, 50, 1'b0);
    run_seq(2'd0, 4'hC, 4'hA, 16'h0005, 40, 1'b0);

    // Slot 3 without END, busy-time noise (ROM writes, starts), then back-to-back.
    for (int a = 48; a < 64; a++) rom_write(6'(a), rand_entry(0));
    run_seq(2'd3, 4'h2, 4'h8, 16'h0001, 0, 1'b1);
    run_seq(2'd1, 4'h4, 4'h6, 16'h0000, 0, 1'b0);
    run_seq(2'd3, 4'hE, 4'h1, 16'h0000, 20, 1'b0);
    idle(3);

    reset_mid_run();
    run_seq(2'd1, 4'h7, 4'h3, 16'h0001, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) rom_write(6'($urandom), rand_entry(30));
      end
      run_seq(2'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
              $urandom_range(0, 50), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
